// File: rtl/d_cache_ctrl_pkg.sv
// d_cache_pkg: shared widths, state encoding, request record and address
// helpers for the direct-mapped data-cache controller (d_cache_ctrl).
//   ADDR_W/INDEX_W/OFFSET_W/DATA_W : address, index, offset and line widths
//   TAG_W                          : derived tag width (55 by default)
//   addr_tag/addr_index/line_addr  : address field extraction
package d_cache_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned MASK_W   = DATA_W / 8;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [MASK_W-1:0]  mask_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_RD_WAIT,
    MEM_WR,
    MEM_WR_WAIT
  } state_e;

  // Request captured on accept; held for the rest of the transaction.
  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t wdata;
    mask_t wmask;
  } req_t;

  function automatic tag_t addr_tag(input addr_t a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic index_t addr_index(input addr_t a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  // Doubleword-aligned address presented to memory.
  function automatic addr_t line_addr(input addr_t a);
    return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/d_cache_ctrl_if.sv
// Bus interfaces of the data-cache controller.
//   d_cache_cpu_if : LSU request/response port
//     master = LSU side, slave = cache side
//     cpu_req_valid/ready handshake, addr, we, wdata, wmask;
//     cpu_resp_valid one-cycle completion pulse with cpu_resp_rdata
//   d_cache_mem_if : memory bus
//     master = cache side, slave = memory side
//     mem_req_valid/ready handshake, addr, we, wdata, wmask;
//     mem_resp_valid with mem_resp_rdata (read data or write ack)
interface d_cache_cpu_if;
  import d_cache_pkg::*;

  logic  cpu_req_valid;
  logic  cpu_req_ready;
  addr_t cpu_req_addr;
  logic  cpu_req_we;
  data_t cpu_req_wdata;
  mask_t cpu_req_wmask;
  logic  cpu_resp_valid;
  data_t cpu_resp_rdata;

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, cpu_req_wmask,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata
  );

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, cpu_req_wmask,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata
  );
endinterface

interface d_cache_mem_if;
  import d_cache_pkg::*;

  logic  mem_req_valid;
  logic  mem_req_ready;
  addr_t mem_req_addr;
  logic  mem_req_we;
  data_t mem_req_wdata;
  mask_t mem_req_wmask;
  logic  mem_resp_valid;
  data_t mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: direct-mapped, write-through / no-write-allocate data-cache
// controller between the LSU and external tag RAM (64 x {valid, 55-bit tag}),
// data RAM (64 x 64-bit) and the memory bus.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   cpu (slave)     : LSU request/response
//   mem (master)    : memory request/response
//   tag_addr/tag_we/tag_wdata, tag_rdata/tag_rvalid : tag RAM (registered read)
//   data_addr/data_we/data_wmask/data_wdata, data_rdata : data RAM (registered read)
//   flush_req/flush_done : only when D_CACHE_FLUSH_EN is defined
// After reset (and after a flush) an INIT sweep clears all 64 valid bits.
module d_cache_ctrl
  import d_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  d_cache_cpu_if.slave      cpu,
  d_cache_mem_if.master     mem,
  output index_t            tag_addr,
  output logic              tag_we,
  output logic [TAG_W:0]    tag_wdata,
  input  tag_t              tag_rdata,
  input  logic              tag_rvalid,
  output index_t            data_addr,
  output logic              data_we,
  output mask_t             data_wmask,
  output data_t             data_wdata,
  input  data_t             data_rdata
`ifdef D_CACHE_FLUSH_EN
  ,
  input  logic              flush_req,
  output logic              flush_done
`endif
);

  state_e state, state_nxt;
  index_t cnt;
  req_t   req;
  logic   accept;
  logic   hit;
  logic   flush_hold;
  logic   sweep_last;

`ifdef D_CACHE_FLUSH_EN
  logic   flush_pend;
  assign flush_hold = flush_req;
`else
  assign flush_hold = 1'b0;
`endif

  assign hit        = tag_rvalid && (tag_rdata == addr_tag(req.addr));
  assign sweep_last = (state == INIT) && (cnt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      // 6-bit counter wraps 63 -> 0, so every sweep starts at index 0.
      if (state == INIT) cnt <= cnt + 1'b1;
      if (accept) begin
        req.we    <= cpu.cpu_req_we;
        req.addr  <= cpu.cpu_req_addr;
        req.wdata <= cpu.cpu_req_wdata;
        req.wmask <= cpu.cpu_req_wmask;
      end
    end
  end

`ifdef D_CACHE_FLUSH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend <= 1'b0;
    end else if (state == IDLE && flush_req) begin
      flush_pend <= 1'b1;
    end else if (sweep_last) begin
      flush_pend <= 1'b0;
    end
  end

  // Pulse on the final sweep cycle, i.e. the INIT -> IDLE transition.
  assign flush_done = flush_pend && sweep_last;
`endif

  always_comb begin
    state_nxt           = state;
    accept              = 1'b0;
    cpu.cpu_req_ready   = 1'b0;
    cpu.cpu_resp_valid  = 1'b0;
    cpu.cpu_resp_rdata  = '0;
    tag_addr            = addr_index(req.addr);
    tag_we              = 1'b0;
    tag_wdata           = '0;
    data_addr           = addr_index(req.addr);
    data_we             = 1'b0;
    data_wmask          = '0;
    data_wdata          = '0;
    mem.mem_req_valid   = 1'b0;
    mem.mem_req_addr    = '0;
    mem.mem_req_we      = 1'b0;
    mem.mem_req_wdata   = '0;
    mem.mem_req_wmask   = '0;

    unique case (state)
      INIT: begin
        tag_addr = cnt;
        // The sweep write is gated by rst so tag_we reads 0 while reset is held.
        tag_we   = rst;
        if (sweep_last) state_nxt = IDLE;
      end

      IDLE: begin
        tag_addr  = addr_index(cpu.cpu_req_addr);
        data_addr = addr_index(cpu.cpu_req_addr);
        if (flush_hold) begin
          state_nxt = INIT;
        end else begin
          cpu.cpu_req_ready = 1'b1;
          if (cpu.cpu_req_valid) begin
            accept    = 1'b1;
            state_nxt = LOOKUP;
          end
        end
      end

      LOOKUP: begin
        if (req.we) begin
          if (hit) begin
            data_we    = 1'b1;
            data_wmask = req.wmask;
            data_wdata = req.wdata;
          end
          state_nxt = MEM_WR;
        end else if (hit) begin
          cpu.cpu_resp_valid = 1'b1;
          cpu.cpu_resp_rdata = data_rdata;
          state_nxt          = IDLE;
        end else begin
          state_nxt = MEM_RD;
        end
      end

      MEM_RD: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = line_addr(req.addr);
        if (mem.mem_req_ready) state_nxt = MEM_RD_WAIT;
      end

      MEM_RD_WAIT: begin
        if (mem.mem_resp_valid) begin
          tag_we             = 1'b1;
          tag_wdata          = {1'b1, addr_tag(req.addr)};
          data_we            = 1'b1;
          data_wmask         = '1;
          data_wdata         = mem.mem_resp_rdata;
          cpu.cpu_resp_valid = 1'b1;
          cpu.cpu_resp_rdata = mem.mem_resp_rdata;
          state_nxt          = IDLE;
        end
      end

      MEM_WR: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = line_addr(req.addr);
        mem.mem_req_we    = 1'b1;
        mem.mem_req_wdata = req.wdata;
        mem.mem_req_wmask = req.wmask;
        if (mem.mem_req_ready) state_nxt = MEM_WR_WAIT;
      end

      MEM_WR_WAIT: begin
        if (mem.mem_resp_valid) begin
          cpu.cpu_resp_valid = 1'b1;
          state_nxt          = IDLE;
        end
      end

      default: state_nxt = INIT;
    endcase
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed testbench for d_cache_ctrl with behavioural tag/data RAM models.
// Memory responses are driven directly by the stimulus sequence.
module tb_d_cache_ctrl;
  import d_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  d_cache_cpu_if cpu_if ();
  d_cache_mem_if mem_if ();

  index_t          tag_addr;
  logic            tag_we;
  logic [TAG_W:0]  tag_wdata;
  tag_t            tag_rdata;
  logic            tag_rvalid;
  index_t          data_addr;
  logic            data_we;
  mask_t           data_wmask;
  data_t           data_wdata;
  data_t           data_rdata;
`ifdef D_CACHE_FLUSH_EN
  logic            flush_req = 1'b0;
  logic            flush_done;
`endif

  d_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .mem        (mem_if),
    .tag_addr   (tag_addr),
    .tag_we     (tag_we),
    .tag_wdata  (tag_wdata),
    .tag_rdata  (tag_rdata),
    .tag_rvalid (tag_rvalid),
    .data_addr  (data_addr),
    .data_we    (data_we),
    .data_wmask (data_wmask),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata)
`ifdef D_CACHE_FLUSH_EN
    ,
    .flush_req  (flush_req),
    .flush_done (flush_done)
`endif
  );

  // Tag RAM: power-up contents are junk that would alias 0x1000 if not swept.
  logic  tv [64];
  tag_t  tm [64];
  data_t dm [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      tv[i] = 1'b1;
      tm[i] = 55'd8;
      dm[i] = 64'h5555_5555_5555_5555;
    end
    tag_rdata  = '0;
    tag_rvalid = 1'b0;
    data_rdata = '0;
  end

  always @(posedge clk) begin
    if (tag_we) begin
      tv[tag_addr] <= tag_wdata[TAG_W];
      tm[tag_addr] <= tag_wdata[TAG_W-1:0];
    end else begin
      tag_rvalid <= tv[tag_addr];
      tag_rdata  <= tm[tag_addr];
    end
  end

  always @(posedge clk) begin
    if (data_we) begin
      for (int b = 0; b < 8; b++)
        if (data_wmask[b]) dm[data_addr][b*8 +: 8] <= data_wdata[b*8 +: 8];
    end
    data_rdata <= dm[data_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"},  64'(cpu_if.cpu_req_ready), 64'd0);
    chk({nm, "_rvalid"}, 64'(cpu_if.cpu_resp_valid), 64'd0);
    chk({nm, "_rdata"},  cpu_if.cpu_resp_rdata, 64'd0);
    chk({nm, "_mvalid"}, 64'(mem_if.mem_req_valid), 64'd0);
    chk({nm, "_tag_we"}, 64'(tag_we), 64'd0);
    chk({nm, "_dat_we"}, 64'(data_we), 64'd0);
  endtask

  // Called right after a negedge where rst has just been released.
  task automatic sweep_check(input string nm);
    for (int i = 0; i < 64; i++) begin
      #1;
      chk({nm, "_sweep"}, {cpu_if.cpu_req_ready, tag_we, tag_addr, tag_wdata},
          {1'b0, 1'b1, 6'(i), 56'd0});
      @(negedge clk);
    end
    #1;
    chk({nm, "_ready_after"}, {62'd0, cpu_if.cpu_req_ready, tag_we}, 64'b10);
  endtask

  // Returns at the negedge where the DUT sits in LOOKUP.
  task automatic issue(input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] wmask);
    int n = 0;
    #1;
    while (!cpu_if.cpu_req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready", 64'(cpu_if.cpu_req_ready), 64'd1);
    cpu_if.cpu_req_valid = 1'b1;
    cpu_if.cpu_req_we    = we;
    cpu_if.cpu_req_addr  = addr;
    cpu_if.cpu_req_wdata = wdata;
    cpu_if.cpu_req_wmask = wmask;
    @(negedge clk);
    cpu_if.cpu_req_valid = 1'b0;
    cpu_if.cpu_req_we    = 1'b0;
  endtask

  // Called at the negedge where the DUT sits in MEM_RD or MEM_WR.
  task automatic mem_txn(input string nm, input int stall, input logic [63:0] rsp,
                         input logic [63:0] exp_addr, input logic exp_we,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                         input logic [55:0] exp_tagw, input logic [5:0] exp_idx);
    #1;
    for (int s = 0; s < stall; s++) begin
      chk({nm, "_stall"}, {mem_if.mem_req_valid, mem_if.mem_req_addr[62:0]},
          {1'b1, exp_addr[62:0]});
      @(negedge clk);
      #1;
    end
    chk({nm, "_mvalid"}, 64'(mem_if.mem_req_valid), 64'd1);
    chk({nm, "_maddr"},  mem_if.mem_req_addr, exp_addr);
    chk({nm, "_mwe"},    64'(mem_if.mem_req_we), 64'(exp_we));
    if (exp_we) begin
      chk({nm, "_mwdata"}, mem_if.mem_req_wdata, exp_wdata);
      chk({nm, "_mwmask"}, 64'(mem_if.mem_req_wmask), 64'(exp_wmask));
    end
    mem_if.mem_req_ready = 1'b1;
    @(negedge clk);
    mem_if.mem_req_ready = 1'b0;
    #1;
    chk({nm, "_wait_mvalid"}, 64'(mem_if.mem_req_valid), 64'd0);
    chk({nm, "_wait_noresp"}, 64'(cpu_if.cpu_resp_valid), 64'd0);
    mem_if.mem_resp_valid = 1'b1;
    mem_if.mem_resp_rdata = rsp;
    #1;
    chk({nm, "_resp_valid"}, 64'(cpu_if.cpu_resp_valid), 64'd1);
    if (!exp_we) begin
      chk({nm, "_resp_rdata"}, cpu_if.cpu_resp_rdata, rsp);
      chk({nm, "_tag_fill"}, {tag_we, tag_addr, tag_wdata}, {1'b1, exp_idx, exp_tagw});
      chk({nm, "_dat_fill"}, {data_we, data_addr, data_wmask}, {1'b1, exp_idx, 8'hFF});
      chk({nm, "_dat_wdata"}, data_wdata, rsp);
    end else begin
      chk({nm, "_no_fill"}, {62'd0, tag_we, data_we}, 64'd0);
    end
    @(negedge clk);
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_rdata = '0;
    #1;
    chk({nm, "_idle"}, {62'd0, cpu_if.cpu_req_ready, cpu_if.cpu_resp_valid}, 64'b10);
  endtask

  task automatic read_hit(input string nm, input logic [63:0] addr, input logic [63:0] exp);
    issue(1'b0, addr, 64'd0, 8'd0);
    #1;
    chk({nm, "_hit_valid"}, 64'(cpu_if.cpu_resp_valid), 64'd1);
    chk({nm, "_hit_rdata"}, cpu_if.cpu_resp_rdata, exp);
    chk({nm, "_hit_nomem"}, 64'(mem_if.mem_req_valid), 64'd0);
    @(negedge clk);
    #1;
    chk({nm, "_hit_t2_ready"}, 64'(cpu_if.cpu_req_ready), 64'd1);
  endtask

  task automatic read_miss(input string nm, input logic [63:0] addr, input int stall,
                           input logic [63:0] rsp, input logic [55:0] exp_tagw,
                           input logic [5:0] exp_idx);
    issue(1'b0, addr, 64'd0, 8'd0);
    #1;
    chk({nm, "_miss_noresp"}, 64'(cpu_if.cpu_resp_valid), 64'd0);
    @(negedge clk);
    mem_txn(nm, stall, rsp, addr, 1'b0, 64'd0, 8'd0, exp_tagw, exp_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cpu_if.cpu_req_valid  = 1'b0;
    cpu_if.cpu_req_addr   = '0;
    cpu_if.cpu_req_we     = 1'b0;
    cpu_if.cpu_req_wdata  = '0;
    cpu_if.cpu_req_wmask  = '0;
    mem_if.mem_req_ready  = 1'b0;
    mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_rdata = '0;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b1;
    sweep_check("por");

    // Cold miss on 0x1000: index 0, tag 8.
    read_miss("rd1000", 64'h1000, 0, 64'hDEAD_BEEF, 56'h80_0000_0000_0008, 6'd0);
    read_hit("rd1000b", 64'h1000, 64'hDEAD_BEEF);

    // Same index, different tag: evicts, with a 5-cycle ready stall.
    read_miss("rd1200", 64'h1200, 5, 64'h1200_CAFE, 56'h80_0000_0000_0009, 6'd0);
    read_miss("rd1000c", 64'h1000, 0, 64'hDEAD_BEEF, 56'h80_0000_0000_0008, 6'd0);

    // Store hit: byte 0 updated in the data RAM and written through.
    issue(1'b1, 64'h1000, 64'hFF, 8'h01);
    #1;
    chk("st_dwe",   {data_we, data_addr, data_wmask}, {1'b1, 6'd0, 8'h01});
    chk("st_dwdata", data_wdata, 64'hFF);
    chk("st_noresp", 64'(cpu_if.cpu_resp_valid), 64'd0);
    @(negedge clk);
    mem_txn("st1000", 0, 64'd0, 64'h1000, 1'b1, 64'hFF, 8'h01, 56'd0, 6'd0);
    read_hit("rd_after_st", 64'h1000, 64'hDEAD_BEFF);

    // Store miss to 0x2008 (index 1, tag 0x10): no RAM write, no allocate.
    issue(1'b1, 64'h2008, 64'h1234_5678_9ABC_DEF0, 8'hF0);
    #1;
    chk("stm_nodwe", 64'(data_we), 64'd0);
    @(negedge clk);
    mem_txn("st2008", 2, 64'd0, 64'h2008, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hF0, 56'd0, 6'd1);

    // Read 0x2008 still misses; reset lands in MEM_RD_WAIT.
    issue(1'b0, 64'h2008, 64'd0, 8'd0);
    #1;
    chk("rd2008_miss", 64'(cpu_if.cpu_resp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("rd2008_mreq", {mem_if.mem_req_valid, mem_if.mem_req_addr[62:0]}, {1'b1, 63'h2008});
    mem_if.mem_req_ready = 1'b1;
    @(negedge clk);
    mem_if.mem_req_ready = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    sweep_check("midrst");

    // Sweep cleared the 0x1000 line.
    read_miss("rd1000_post", 64'h1000, 0, 64'h0BAD_F00D, 56'h80_0000_0000_0008, 6'd0);

`ifdef D_CACHE_FLUSH_EN
    #1;
    flush_req = 1'b1;
    #1;
    chk("fl_ready", 64'(cpu_if.cpu_req_ready), 64'd0);
    @(negedge clk);
    flush_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("fl_sweep", {tag_we, tag_addr, flush_done}, {1'b1, 6'(i), (i == 63)});
      @(negedge clk);
    end
    #1;
    chk("fl_idle", {62'd0, cpu_if.cpu_req_ready, flush_done}, 64'b10);
    read_miss("rd1000_fl", 64'h1000, 0, 64'hDEAD_BEEF, 56'h80_0000_0000_0008, 6'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
